hazard_scoreboard_unit: RTL and testbench
=========================================

Name: hazard_scoreboard_unit

Overview:
Parametrised successor to the fixed 2-source, M/WB-only hazard unit of the 5-stage CPU. It tracks every in-flight register-writing instruction from E through a configurable number of post-E stages, each with its own result latency. It produces stall/flush controls for F, D and E, and registered per-source forwarding selects for E. It supports NUMSRC source operands and multi-cycle-latency producers (loads, future multiply).

Parameters:
ADDRESSWIDTH, 4, register address width
NUMSRC, 2, source operands per instruction
FWDDEPTH, 2, post-E stages that can forward (1=M, 2=WB, ...); stage FWDDEPTH is write-back
SELW, $clog2(FWDDEPTH+1), width of forward select and latency fields

Ports:
clock  in  1  single clock
reset  in  1  synchronous, active-high
decValid  in  1  D holds a real instruction
decWriteEn  in  1  D instruction writes a register
decDest  in  ADDRESSWIDTH  D destination register
decLat  in  SELW  post-E stage index at which the result becomes forwardable (1..FWDDEPTH)
decSrcUsed  in  NUMSRC  per-source "operand read" flags
decSrcAddr  in  NUMSRC*ADDRESSWIDTH  packed source addresses, source 0 in LSBs
takeBranchE  in  1  branch taken, resolved in E
stallF  out  1  hold PC
stallD  out  1  hold F/D register
flushD  out  1  clear F/D register
flushE  out  1  insert bubble into D/E register
fwdSelE  out  NUMSRC*SELW  registered; 0 = register-file value, k = forward from post-E stage k

Behaviour:
- Clock is clock; reset is synchronous and active-high.
- Tracking pipe has FWDDEPTH+1 entries, pos 0 = E and pos k = post-E stage k. Each entry holds {valid, dest, lat}.
  - Every cycle, pos k+1 <= pos k unconditionally. The entry leaving pos FWDDEPTH is dropped.
  - pos 0 <= {decValid&decWriteEn, decDest, max(decLat,1)} when issuing. Otherwise pos 0 <= bubble.
  - issue = decValid & !hazard & !takeBranchE.
- Hazard check, combinational, for each source s with decSrcUsed[s]=1:
  - Scan pos 0..FWDDEPTH-1 from youngest to oldest. The youngest valid entry with dest==decSrcAddr[s] is the producer at position p.
  - The producer sits at p+1 when the consumer reaches E. It is ready iff p+1 >= lat.
  - Not ready -> hazard=1. A ready producer gives sel = p+1. No match gives sel = 0.
  - An entry at pos FWDDEPTH never matches; it has been written back by then.
- Outputs:
  - takeBranchE=1: flushD=1, flushE=1, stallF=0, stallD=0. Branch overrides hazard.
  - Else hazard=1: stallF=1, stallD=1, flushE=1, flushD=0.
  - Else all four are 0.
- fwdSelE is registered. It loads the computed sels on issue and loads all zeros otherwise.
- Latency: a hazard resolves in exactly lat-(p+1) stall cycles; a forward-select decision takes 1 cycle.
- Reset:
  - All pipe entries invalid; fwdSelE=0.
  - While reset=1: flushD=flushE=1, stallF=stallD=0.
  - Reset mid-stall discards the pending producer, and the consumer re-evaluates as clean.
- decValid=0 or decSrcUsed[s]=0 never causes a stall.
- decLat greater than FWDDEPTH is clamped to FWDDEPTH.

Optional Feature:
Macro HAZARD_PERF_EN.
- Defined: adds outputs stallCount and flushCount, 32 bits each. They count cycles with a hazard stall and cycles with a branch flush, saturate at all-ones, and clear on reset.
- Undefined: these ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package cpu_hazard_pkg:
  - FWD_REGFILE=0 constant.
  - inflight_t struct {valid, dest, lat}.
  - clamp-latency function.
- One sub-module, hazard_inflight_pipe. It is the FWDDEPTH+1 entry shift register with issue/bubble insert and reset, exposing all entries.
- The match/priority logic stays in the top module.

Test Plan:
All scenarios use FWDDEPTH=2.
1. ALU r3 (lat 1), then next instr reads r3 on src0 -> no stall, fwdSelE src0 = 1 on the following cycle.
2. Load r3 (lat 2), then reader of r3 -> exactly 1 cycle of stallF=stallD=flushE=1, then issue with src0 sel = 2.
3. Same-register producers: r5 (lat 1) then r5 (lat 1), then a reader -> src0 sel = 1 (youngest wins), no stall.
4. Reader of r3 issued 3 instructions after the r3 producer -> sel = 0; unused source (decSrcUsed=0) matching a lat-2 producer -> no stall.
5. Load-use hazard with takeBranchE=1 in the same cycle -> flushD=flushE=1, stallF=stallD=0; the next cycle shows no stale hazard.
6. Assert reset during a load-use stall -> the next cycle has all entries invalid and fwdSelE=0, and the reader issues without stall once reset deasserts.

Source files
------------

// File: rtl/hazard_scoreboard_unit_pkg.sv
// cpu_hazard_pkg: shared scoreboard types, forward-select encoding and latency clamp helper
package cpu_hazard_pkg;
  localparam int FWD_REGFILE = 0;
  localparam int DEF_ADDRW = 4;
  localparam int DEF_SELW = 2;
  typedef struct packed {
    logic valid;
    logic [DEF_ADDRW-1:0] dest;
    logic [DEF_SELW-1:0] lat;
  } inflight_t;
  function automatic int clampLat(input int lat, input int depth);
    return lat < 1 ? 1 : (lat > depth ? depth : lat);
  endfunction
endpackage

// File: rtl/hazard_inflight_pipe.sv
// hazard_inflight_pipe: FWDDEPTH+1 entry in-flight shift register, pos 0 = E, issue or bubble insert
module hazard_inflight_pipe
  import cpu_hazard_pkg::*;
#(
  parameter int FWDDEPTH = 2,
  parameter type entryT = inflight_t
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  issue,
  input  entryT ins,
  output entryT ents [FWDDEPTH+1]
);
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k <= FWDDEPTH; k++) ents[k] <= '0;
    end else begin
      ents[0] <= issue ? ins : '0;
      for (int k = 1; k <= FWDDEPTH; k++) ents[k] <= ents[k-1];
    end
  end
endmodule

// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit: scoreboard stall/flush control plus registered forward selects; HAZARD_PERF_EN adds stall/flush counters
module hazard_scoreboard_unit
  import cpu_hazard_pkg::*;
#(
  parameter int ADDRESSWIDTH = 4,
  parameter int NUMSRC = 2,
  parameter int FWDDEPTH = 2,
  parameter int SELW = $clog2(FWDDEPTH + 1)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           decValid,
  input  logic                           decWriteEn,
  input  logic [ADDRESSWIDTH-1:0]        decDest,
  input  logic [SELW-1:0]                decLat,
  input  logic [NUMSRC-1:0]              decSrcUsed,
  input  logic [NUMSRC*ADDRESSWIDTH-1:0] decSrcAddr,
  input  logic                           takeBranchE,
  output logic                           stallF,
  output logic                           stallD,
  output logic                           flushD,
  output logic                           flushE,
  output logic [NUMSRC*SELW-1:0]         fwdSelE
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]                    stallCount,
  output logic [31:0]                    flushCount
`endif
);
  typedef struct packed {
    logic valid;
    logic [ADDRESSWIDTH-1:0] dest;
    logic [SELW-1:0] lat;
  } entryT;
  entryT ents [FWDDEPTH+1];
  entryT ins;
  logic hazard;
  logic issue;
  logic [NUMSRC-1:0] found;
  logic [NUMSRC*SELW-1:0] sel;
  hazard_inflight_pipe #(.FWDDEPTH(FWDDEPTH), .entryT(entryT)) pipe (
    .clock(clock),
    .reset(reset),
    .issue(issue),
    .ins(ins),
    .ents(ents)
  );
  // youngest-first scan; the write-back slot is excluded since the register file already holds it
  always_comb begin
    hazard = 1'b0;
    found = '0;
    sel = {NUMSRC{SELW'(FWD_REGFILE)}};
    for (int s = 0; s < NUMSRC; s++) begin
      for (int p = 0; p < FWDDEPTH; p++) begin
        if (decValid && decSrcUsed[s] && !found[s] && ents[p].valid &&
            ents[p].dest == decSrcAddr[s*ADDRESSWIDTH +: ADDRESSWIDTH]) begin
          found[s] = 1'b1;
          if (p + 1 >= int'(ents[p].lat)) sel[s*SELW +: SELW] = SELW'(p + 1);
          else hazard = 1'b1;
        end
      end
    end
  end
  assign issue = decValid & ~hazard & ~takeBranchE;
  assign ins = '{valid: decWriteEn, dest: decDest, lat: SELW'(clampLat(int'(decLat), FWDDEPTH))};
  assign stallF = ~reset & ~takeBranchE & hazard;
  assign stallD = stallF;
  assign flushD = reset | takeBranchE;
  assign flushE = flushD | hazard;
  always_ff @(posedge clock) begin
    if (reset) fwdSelE <= '0;
    else fwdSelE <= issue ? sel : {NUMSRC{SELW'(FWD_REGFILE)}};
  end
`ifdef HAZARD_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stallCount <= '0;
      flushCount <= '0;
    end else begin
      if (stallF && !(&stallCount)) stallCount <= stallCount + 32'd1;
      if (takeBranchE && !(&flushCount)) flushCount <= flushCount + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb_hazard_scoreboard_unit: table-driven checks of stall/flush controls with a queue of expected forward selects
module tb_hazard_scoreboard_unit;
  logic clock = 1'b0;
  logic reset;
  logic decValid, decWriteEn, takeBranchE;
  logic [3:0] decDest;
  logic [1:0] decLat, decSrcUsed;
  logic [7:0] decSrcAddr;
  logic stallF, stallD, flushD, flushE;
  logic [3:0] fwdSelE;
`ifdef HAZARD_PERF_EN
  logic [31:0] stallCount, flushCount;
`endif
  always #5 clock = ~clock;
  hazard_scoreboard_unit #(.ADDRESSWIDTH(4), .NUMSRC(2), .FWDDEPTH(2)) dut (
    .clock(clock),
    .reset(reset),
    .decValid(decValid),
    .decWriteEn(decWriteEn),
    .decDest(decDest),
    .decLat(decLat),
    .decSrcUsed(decSrcUsed),
    .decSrcAddr(decSrcAddr),
    .takeBranchE(takeBranchE),
    .stallF(stallF),
    .stallD(stallD),
    .flushD(flushD),
    .flushE(flushE),
    .fwdSelE(fwdSelE)
`ifdef HAZARD_PERF_EN
    ,
    .stallCount(stallCount),
    .flushCount(flushCount)
`endif
  );
  typedef struct {
    logic v, we;
    logic [3:0] dest;
    logic [1:0] lat, used;
    logic [3:0] s0, s1;
    logic br;
    logic [3:0] ctl;
    logic [1:0] sel0, sel1;
  } vec_t;
  localparam logic [3:0] NONE = 4'b0000, STALL = 4'b1101, BRANCH = 4'b0011;
  vec_t tbl[$];
  logic [3:0] selQ[$];
  int checks = 0, errors = 0, expStalls = 0, expFlushes = 0;
  function automatic vec_t mk(logic v, logic we, logic [3:0] dest, logic [1:0] lat, logic [1:0] used,
                              logic [3:0] s0, logic [3:0] s1, logic br, logic [3:0] ctl,
                              logic [1:0] sel0, logic [1:0] sel1);
    vec_t r;
    r.v = v; r.we = we; r.dest = dest; r.lat = lat; r.used = used;
    r.s0 = s0; r.s1 = s1; r.br = br; r.ctl = ctl; r.sel0 = sel0; r.sel1 = sel1;
    return r;
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(input vec_t v);
    decValid = v.v; decWriteEn = v.we; decDest = v.dest; decLat = v.lat;
    decSrcUsed = v.used; decSrcAddr = {v.s1, v.s0}; takeBranchE = v.br;
  endtask
  task automatic step(input vec_t v, input int idx);
    @(posedge clock);
    #1;
    if (selQ.size() > 0) check($sformatf("fwdSelE[%0d]", idx), 32'(fwdSelE), 32'(selQ.pop_front()));
    drive(v);
    #1;
    check($sformatf("ctl[%0d]", idx), 32'({stallF, stallD, flushD, flushE}), 32'(v.ctl));
    selQ.push_back((v.v && !v.ctl[3] && !v.br) ? {v.sel1, v.sel0} : 4'h0);
    expStalls += int'(v.ctl[3]);
    expFlushes += int'(v.br);
  endtask
  initial begin
    vec_t idle, ld3, rd3;
    idle = mk(0, 0, 0, 0, 2'b00, 0, 0, 0, NONE, 0, 0);
    // scenario 1: ALU forward from M
    tbl.push_back(mk(1, 1, 3, 1, 2'b00, 0, 0, 0, NONE, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 2'b01, 3, 9, 0, NONE, 1, 0));
    tbl.push_back(idle);
    // scenario 2: load-use one stall, then forward from WB; WB slot never matches
    tbl.push_back(mk(1, 1, 3, 2, 2'b00, 0, 0, 0, NONE, 0, 0));
    tbl.push_back(mk(1, 1, 4, 1, 2'b01, 3, 0, 0, STALL, 0, 0));
    tbl.push_back(mk(1, 1, 4, 1, 2'b01, 3, 0, 0, NONE, 2, 0));
    tbl.push_back(mk(1, 0, 0, 1, 2'b11, 4, 3, 0, NONE, 1, 0));
    // scenario 3: youngest producer wins
    tbl.push_back(mk(1, 1, 5, 1, 2'b00, 0, 0, 0, NONE, 0, 0));
    tbl.push_back(mk(1, 1, 5, 1, 2'b00, 0, 0, 0, NONE, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 2'b10, 0, 5, 0, NONE, 0, 1));
    // scenario 4: distant producer, unused source, invalid instruction
    tbl.push_back(mk(1, 1, 3, 1, 2'b00, 0, 0, 0, NONE, 0, 0));
    tbl.push_back(idle);
    tbl.push_back(idle);
    tbl.push_back(mk(1, 0, 0, 1, 2'b01, 3, 0, 0, NONE, 0, 0));
    tbl.push_back(mk(1, 1, 6, 2, 2'b00, 0, 0, 0, NONE, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 2'b00, 6, 6, 0, NONE, 0, 0));
    tbl.push_back(mk(1, 1, 7, 2, 2'b00, 0, 0, 0, NONE, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 2'b01, 7, 0, 0, NONE, 0, 0));
    // latency clamping: 3 behaves as 2, 0 behaves as 1
    tbl.push_back(mk(1, 1, 8, 3, 2'b00, 0, 0, 0, NONE, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 2'b10, 0, 8, 0, STALL, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 2'b10, 0, 8, 0, NONE, 0, 2));
    tbl.push_back(mk(1, 1, 9, 0, 2'b00, 0, 0, 0, NONE, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 2'b01, 9, 0, 0, NONE, 1, 0));
    // scenario 5: branch overrides load-use hazard, no stale hazard afterwards
    tbl.push_back(mk(1, 1, 3, 2, 2'b00, 0, 0, 0, NONE, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 2'b01, 3, 0, 1, BRANCH, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 2'b01, 3, 0, 0, NONE, 2, 0));
    tbl.push_back(mk(1, 0, 0, 1, 2'b00, 0, 0, 1, BRANCH, 0, 0));
    tbl.push_back(idle);
    tbl.push_back(idle);
    drive(idle);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("reset ctl", 32'({stallF, stallD, flushD, flushE}), 32'(BRANCH));
    check("reset fwdSelE", 32'(fwdSelE), 32'h0);
    reset = 1'b0;
    foreach (tbl[i]) step(tbl[i], i);
`ifdef HAZARD_PERF_EN
    @(posedge clock);
    #1;
    check("stallCount", stallCount, 32'(expStalls));
    check("flushCount", flushCount, 32'(expFlushes));
`endif
    // scenario 6: reset during a load-use stall drops the pending producer
    ld3 = mk(1, 1, 3, 2, 2'b00, 0, 0, 0, NONE, 0, 0);
    rd3 = mk(1, 0, 0, 1, 2'b01, 3, 0, 0, STALL, 0, 0);
    step(ld3, 100);
    step(rd3, 101);
    reset = 1'b1;
    #1;
    check("reset-in-stall ctl", 32'({stallF, stallD, flushD, flushE}), 32'(BRANCH));
    @(posedge clock);
    #1;
    reset = 1'b0;
    selQ.delete();
    check("reset-in-stall fwdSelE", 32'(fwdSelE), 32'h0);
    #1;
    check("post-reset ctl", 32'({stallF, stallD, flushD, flushE}), 32'(NONE));
    selQ.push_back(4'h0);
    step(idle, 102);
    @(posedge clock);
    #1;
    check("post-reset fwdSelE", 32'(fwdSelE), 32'(selQ.pop_front()));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
